sensor_packet_parser: RTL and testbench

Receive-side deframer for the 9-byte sensor packet produced by the controller's packet builder. It consumes a byte stream from the UART receive path, hunts for the 0x7E start delimiter, validates the length, reserved bits, checksum and end delimiter, then presents the decoded sensor_id, timestamp and sensor_data on a single-entry valid/ready output. It sits between the UART RX byte interface and the host-side consumer, and counts good and bad frames for diagnostics.

---
 rtl/sensor_packet_parser.sv | 208 ++++++++++++++++++++
 tb/tb_sensor_packet_parser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_packet_parser.sv
// Receive-side deframer for the 9-byte sensor packet: hunts for 0x7E and checks length, reserved bits, checksum and end delimiter.
// It presents decoded fields on a single-entry output register and counts good and bad frames.
module sensor_packet_parser #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 pkt_valid,
   input  logic                 pkt_ready,
   output logic [1:0]           pkt_sensor_id,
   output logic [15:0]          pkt_timestamp,
   output logic [15:0]          pkt_data,
   output logic                 err_frame,
   output logic                 err_length,
   output logic                 err_checksum,
   output logic                 err_overflow,
   output logic                 err_timeout,
   output logic [CNT_WIDTH-1:0] good_count,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic [3:0]           dbg_state
);

   // Handshakes: a byte moves on in_valid && in_ready; a packet moves on pkt_valid && pkt_ready,
   // and the packet fields hold while pkt_valid && !pkt_ready.
   typedef enum logic [3:0] {
      S_HUNT  = 4'd0,
      S_ID    = 4'd1,
      S_LEN   = 4'd2,
      S_TS_HI = 4'd3,
      S_TS_LO = 4'd4,
      S_D_HI  = 4'd5,
      S_D_LO  = 4'd6,
      S_CHK   = 4'd7,
      S_END   = 4'd8
   } state_t;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t                r_state;
   logic [7:0]            r_xor;
   logic                  r_chk_bad;
   logic [1:0]            r_sid;
   logic [15:0]           r_ts;
   logic [15:0]           r_data;
   logic [TW-1:0]         r_tmo;
   logic                  r_pkt_valid;
   logic [1:0]            r_pkt_sid;
   logic [15:0]           r_pkt_ts;
   logic [15:0]           r_pkt_data;
   logic                  r_err_frame;
   logic                  r_err_length;
   logic                  r_err_checksum;
   logic                  r_err_overflow;
   logic                  r_err_timeout;
   logic [CNT_WIDTH-1:0]  r_good_count;
   logic [CNT_WIDTH-1:0]  r_err_count;

   logic w_acc;
   logic w_timeout;
   logic w_byte;
   logic w_pkt_free;
   logic w_good_end;
   logic w_load;
   logic w_e_frame;
   logic w_e_len;
   logic w_e_chk;
   logic w_e_ovf;
   logic w_err_any;

   assign in_ready   = !rst;
   assign w_acc      = in_valid && in_ready;
   // A byte arriving on the timeout cycle is dropped; hunting resumes next cycle.
   assign w_timeout  = (r_state != S_HUNT) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
   assign w_byte     = w_acc && !w_timeout;
   assign w_pkt_free = !r_pkt_valid || pkt_ready;
   assign w_good_end = w_byte && (r_state == S_END) && (in_data == 8'h7E) && !r_chk_bad;
   assign w_load     = w_good_end && w_pkt_free;

   assign w_e_frame = w_byte && (((r_state == S_ID) && (in_data != 8'h7E) && (in_data[5:0] != 6'd0)) ||
                                 ((r_state == S_END) && (in_data != 8'h7E)));
   assign w_e_len   = w_byte && (r_state == S_LEN) && (in_data != 8'h08);
   assign w_e_chk   = w_byte && (r_state == S_END) && (in_data == 8'h7E) && r_chk_bad;
   assign w_e_ovf   = w_good_end && !w_pkt_free;
   assign w_err_any = w_e_frame || w_e_len || w_e_chk || w_e_ovf || w_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_HUNT;
         r_xor          <= 8'd0;
         r_chk_bad      <= 1'b0;
         r_sid          <= 2'd0;
         r_ts           <= 16'd0;
         r_data         <= 16'd0;
         r_tmo          <= '0;
         r_pkt_valid    <= 1'b0;
         r_pkt_sid      <= 2'd0;
         r_pkt_ts       <= 16'd0;
         r_pkt_data     <= 16'd0;
         r_err_frame    <= 1'b0;
         r_err_length   <= 1'b0;
         r_err_checksum <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_good_count   <= '0;
         r_err_count    <= '0;
      end else begin
         r_err_frame    <= w_e_frame;
         r_err_length   <= w_e_len;
         r_err_checksum <= w_e_chk;
         r_err_overflow <= w_e_ovf;
         r_err_timeout  <= w_timeout;

         if (w_load && (r_good_count != '1))
            r_good_count <= r_good_count + CNT_WIDTH'(1);
         if (w_err_any && (r_err_count != '1))
            r_err_count <= r_err_count + CNT_WIDTH'(1);

         if (w_load) begin
            r_pkt_valid <= 1'b1;
            r_pkt_sid   <= r_sid;
            r_pkt_ts    <= r_ts;
            r_pkt_data  <= r_data;
         end else if (r_pkt_valid && pkt_ready) begin
            r_pkt_valid <= 1'b0;
         end

         if (w_timeout || w_acc || (r_state == S_HUNT))
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + TW'(1);

         if (w_timeout) begin
            r_state <= S_HUNT;
         end else if (w_byte) begin
            case (r_state)
               S_HUNT: begin
                  if (in_data == 8'h7E) begin
                     r_state <= S_ID;
                     r_xor   <= 8'd0;
                  end
               end
               S_ID: begin
                  if (in_data == 8'h7E) begin
                     r_xor <= 8'd0;
                  end else if (in_data[5:0] != 6'd0) begin
                     r_state <= S_HUNT;
                  end else begin
                     r_sid   <= in_data[7:6];
                     r_xor   <= in_data;
                     r_state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (in_data != 8'h08) begin
                     r_state <= S_HUNT;
                  end else begin
                     r_xor   <= r_xor ^ in_data;
                     r_state <= S_TS_HI;
                  end
               end
               S_TS_HI: begin
                  r_ts[15:8] <= in_data;
                  r_xor      <= r_xor ^ in_data;
                  r_state    <= S_TS_LO;
               end
               S_TS_LO: begin
                  r_ts[7:0] <= in_data;
                  r_xor     <= r_xor ^ in_data;
                  r_state   <= S_D_HI;
               end
               S_D_HI: begin
                  r_data[15:8] <= in_data;
                  r_xor        <= r_xor ^ in_data;
                  r_state      <= S_D_LO;
               end
               S_D_LO: begin
                  r_data[7:0] <= in_data;
                  r_xor       <= r_xor ^ in_data;
                  r_state     <= S_CHK;
               end
               S_CHK: begin
                  r_chk_bad <= (in_data != r_xor);
                  r_state   <= S_END;
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   assign pkt_valid     = r_pkt_valid;
   assign pkt_sensor_id = r_pkt_sid;
   assign pkt_timestamp = r_pkt_ts;
   assign pkt_data      = r_pkt_data;
   assign err_frame     = r_err_frame;
   assign err_length    = r_err_length;
   assign err_checksum  = r_err_checksum;
   assign err_overflow  = r_err_overflow;
   assign err_timeout   = r_err_timeout;
   assign good_count    = r_good_count;
   assign err_count     = r_err_count;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_sensor_packet_parser.sv
// Bench for sensor_packet_parser: directed frames from the test plan, then randomized
// good/corrupted frames checked against a frame-level reference model.
module tb_sensor_packet_parser;

   localparam int T  = 20;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready;
   logic          pkt_valid;
   logic          pkt_ready = 1'b0;
   logic [1:0]    pkt_sensor_id;
   logic [15:0]   pkt_timestamp;
   logic [15:0]   pkt_data;
   logic          err_frame, err_length, err_checksum, err_overflow, err_timeout;
   logic [CW-1:0] good_count, err_count;
   logic [3:0]    dbg_state;

   sensor_packet_parser #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_sensor_id(pkt_sensor_id),
      .pkt_timestamp(pkt_timestamp), .pkt_data(pkt_data), .err_frame(err_frame),
      .err_length(err_length), .err_checksum(err_checksum), .err_overflow(err_overflow),
      .err_timeout(err_timeout), .good_count(good_count), .err_count(err_count),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [33:0] exp_q[$];
   logic [7:0]  fb[9];
   logic [7:0]  bq[$];
   int m_good = 0;
   int m_err  = 0;
   int o_frame = 0, o_len = 0, o_chk = 0, o_ovf = 0, o_tmo = 0;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_q();
      foreach (bq[i]) send_byte(bq[i]);
   endtask

   // Wire image of a well-formed frame; checksum is the XOR of the six payload bytes.
   task automatic build(input logic [1:0] sid, input logic [15:0] ts, input logic [15:0] d);
      fb[0] = 8'h7E;
      fb[1] = {sid, 6'd0};
      fb[2] = 8'h08;
      fb[3] = ts[15:8];
      fb[4] = ts[7:0];
      fb[5] = d[15:8];
      fb[6] = d[7:0];
      fb[7] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4] ^ fb[5] ^ fb[6];
      fb[8] = 8'h7E;
   endtask

   task automatic send_fb(input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         step($urandom_range(0, max_gap));
         send_byte(fb[i]);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         o_frame = 0; o_len = 0; o_chk = 0; o_ovf = 0; o_tmo = 0;
      end else begin
         if (pkt_valid && pkt_ready) begin
            chk("pkt_expected", 34'(exp_q.size() != 0), 34'(1));
            if (exp_q.size() != 0)
               chk("pkt_fields", {pkt_sensor_id, pkt_timestamp, pkt_data}, exp_q.pop_front());
         end
         o_frame += int'(err_frame);
         o_len   += int'(err_length);
         o_chk   += int'(err_checksum);
         o_ovf   += int'(err_overflow);
         o_tmo   += int'(err_timeout);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int e_frame, e_len, e_chk;
      int s_frame, s_len, s_chk, s_ovf, s_tmo;
      logic [1:0]  sid;
      logic [15:0] ts, dd;

      // Reset state
      rst = 1'b1;
      step(3);
      chk("rst_in_ready", 34'(in_ready), 34'(0));
      chk("rst_pkt_valid", 34'(pkt_valid), 34'(0));
      chk("rst_good_count", 34'(good_count), 34'(0));
      chk("rst_err_count", 34'(err_count), 34'(0));
      chk("rst_fields", {pkt_sensor_id, pkt_timestamp, pkt_data}, 34'(0));
      chk("rst_state", 34'(dbg_state), 34'(0));
      rst = 1'b0;
      #1;
      chk("in_ready_out_of_reset", 34'(in_ready), 34'(1));
      step(1);

      // Basic frame with consumer ready
      pkt_ready = 1'b1;
      exp_q.push_back({2'd2, 16'h1234, 16'hABCD});
      bq = '{8'h7E, 8'h80, 8'h08, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC8, 8'h7E};
      send_q();
      m_good = sat(m_good);
      chk("t1_pkt_valid", 34'(pkt_valid), 34'(1));
      chk("t1_sid", 34'(pkt_sensor_id), 34'(2));
      chk("t1_ts", 34'(pkt_timestamp), 34'(16'h1234));
      chk("t1_data", 34'(pkt_data), 34'(16'hABCD));
      chk("t1_good_count", 34'(good_count), 34'(m_good));
      step(1);
      chk("t1_consumed", 34'(pkt_valid), 34'(0));

      // Bad checksum, then a good frame
      bq = '{8'h7E, 8'h80, 8'h08, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC9, 8'h7E};
      send_q();
      m_err = sat(m_err);
      chk("t2_err_checksum", 34'(err_checksum), 34'(1));
      chk("t2_no_pkt", 34'(pkt_valid), 34'(0));
      chk("t2_err_count", 34'(err_count), 34'(m_err));
      step(1);
      chk("t2_pulse_width", 34'(err_checksum), 34'(0));
      build(2'd3, 16'hBEEF, 16'h0F0F);
      exp_q.push_back({2'd3, 16'hBEEF, 16'h0F0F});
      send_fb(9, 0);
      m_good = sat(m_good);
      chk("t2b_pkt_valid", 34'(pkt_valid), 34'(1));
      chk("t2b_good_count", 34'(good_count), 34'(m_good));
      step(2);

      // Leading garbage and a doubled start delimiter
      exp_q.push_back({2'd1, 16'h0001, 16'h0002});
      bq = '{8'h00, 8'h55, 8'h7E, 8'h7E, 8'h40, 8'h08, 8'h00, 8'h01, 8'h00, 8'h02, 8'h4B, 8'h7E};
      send_q();
      m_good = sat(m_good);
      chk("t3_pkt_valid", 34'(pkt_valid), 34'(1));
      chk("t3_fields", {pkt_sensor_id, pkt_timestamp, pkt_data}, {2'd1, 16'h0001, 16'h0002});
      step(2);

      // Length, reserved-bit and end-delimiter errors
      bq = '{8'h7E, 8'h80, 8'h09};
      send_q();
      chk("t4_err_length", 34'(err_length), 34'(1));
      bq = '{8'h7E, 8'h81};
      send_q();
      chk("t4_err_reserved", 34'(err_frame), 34'(1));
      bq = '{8'h7E, 8'h80, 8'h08, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC8, 8'h7F};
      send_q();
      chk("t4_err_end", 34'(err_frame), 34'(1));
      chk("t4_end_not_chk", 34'(err_checksum), 34'(0));
      bq = '{8'h7E, 8'h80, 8'h08, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC9, 8'h7F};
      send_q();
      chk("t4_end_precedence", {err_frame, err_checksum}, 34'(2'b10));
      repeat (4) m_err = sat(m_err);
      chk("t4_pkt_valid", 34'(pkt_valid), 34'(0));
      step(1);
      chk("t4_err_count", 34'(err_count), 34'(m_err));

      // Overflow while the output is held
      pkt_ready = 1'b0;
      build(2'd0, 16'h1111, 16'h2222);
      exp_q.push_back({2'd0, 16'h1111, 16'h2222});
      send_fb(9, 0);
      m_good = sat(m_good);
      chk("t5_first_valid", 34'(pkt_valid), 34'(1));
      build(2'd3, 16'h3333, 16'h4444);
      send_fb(9, 0);
      m_err = sat(m_err);
      chk("t5_err_overflow", 34'(err_overflow), 34'(1));
      chk("t5_held_fields", {pkt_sensor_id, pkt_timestamp, pkt_data}, {2'd0, 16'h1111, 16'h2222});
      step(3);
      chk("t5_still_valid", 34'(pkt_valid), 34'(1));
      chk("t5_good_count", 34'(good_count), 34'(m_good));
      chk("t5_err_count", 34'(err_count), 34'(m_err));
      pkt_ready = 1'b1;
      step(1);
      chk("t5_drained", 34'(pkt_valid), 34'(0));

      // Inter-byte timeout
      bq = '{8'h7E, 8'h80, 8'h08};
      send_q();
      k = 0;
      for (int i = 1; i <= 3 * T; i++) begin
         step(1);
         if (err_timeout) begin
            k = i;
            break;
         end
      end
      chk("t6_timeout_seen", 34'(k != 0), 34'(1));
      chk("t6_timeout_window", 34'((k >= T - 1) && (k <= T + 1)), 34'(1));
      chk("t6_state_hunt", 34'(dbg_state), 34'(0));
      m_err = sat(m_err);
      chk("t6_err_count", 34'(err_count), 34'(m_err));
      step(1);
      chk("t6_pulse_width", 34'(err_timeout), 34'(0));

      // Randomized frames against the frame-level model
      e_frame = 0; e_len = 0; e_chk = 0;
      s_frame = o_frame; s_len = o_len; s_chk = o_chk; s_ovf = o_ovf; s_tmo = o_tmo;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 3)) begin
            logic [7:0] g;
            g = 8'($urandom_range(0, 255));
            if (g == 8'h7E) g = 8'h00;
            send_byte(g);
         end
         sid = 2'($urandom_range(0, 3));
         ts  = 16'($urandom_range(0, 65535));
         dd  = 16'($urandom_range(0, 65535));
         build(sid, ts, dd);
         case ($urandom_range(0, 5))
            0, 1: begin
               exp_q.push_back({sid, ts, dd});
               m_good = sat(m_good);
               send_fb(9, 3);
            end
            2: begin
               fb[7] = fb[7] ^ 8'($urandom_range(1, 255));
               e_chk++; m_err = sat(m_err);
               send_fb(9, 3);
            end
            3: begin
               fb[2] = 8'($urandom_range(9, 255));
               e_len++; m_err = sat(m_err);
               send_fb(3, 3);
            end
            4: begin
               fb[1] = {sid, 6'($urandom_range(1, 63))};
               if (fb[1] == 8'h7E) fb[1] = 8'h7F;
               e_frame++; m_err = sat(m_err);
               send_fb(2, 3);
            end
            default: begin
               fb[8] = 8'($urandom_range(0, 125));
               if ($urandom_range(0, 1) == 1) fb[7] = ~fb[7];
               e_frame++; m_err = sat(m_err);
               send_fb(9, 3);
            end
         endcase
         step(2);
         chk("rand_good_count", 34'(good_count), 34'(m_good));
         chk("rand_err_count", 34'(err_count), 34'(m_err));
      end
      chk("rand_queue_empty", 34'(exp_q.size()), 34'(0));
      chk("rand_err_frame", 34'(o_frame - s_frame), 34'(e_frame));
      chk("rand_err_length", 34'(o_len - s_len), 34'(e_len));
      chk("rand_err_checksum", 34'(o_chk - s_chk), 34'(e_chk));
      chk("rand_err_other", 34'((o_ovf - s_ovf) + (o_tmo - s_tmo)), 34'(0));

      // Reset mid-frame, then a clean frame
      bq = '{8'h7E, 8'h80, 8'h08, 8'h12};
      send_q();
      rst = 1'b1;
      step(2);
      chk("t7_in_ready", 34'(in_ready), 34'(0));
      chk("t7_pkt_valid", 34'(pkt_valid), 34'(0));
      chk("t7_fields", {pkt_sensor_id, pkt_timestamp, pkt_data}, 34'(0));
      chk("t7_counts", {good_count, err_count}, 34'(0));
      chk("t7_state", 34'(dbg_state), 34'(0));
      chk("t7_errs", {err_frame, err_length, err_checksum, err_overflow, err_timeout}, 34'(0));
      exp_q.delete();
      m_good = 0;
      m_err  = 0;
      rst = 1'b0;
      step(1);
      build(2'd1, 16'hCAFE, 16'h7E7E);
      exp_q.push_back({2'd1, 16'hCAFE, 16'h7E7E});
      send_fb(9, 2);
      m_good = sat(m_good);
      chk("t7_pkt_valid_after", 34'(pkt_valid), 34'(1));
      chk("t7_fields_after", {pkt_sensor_id, pkt_timestamp, pkt_data}, {2'd1, 16'hCAFE, 16'h7E7E});
      step(2);
      chk("t7_good_count", 34'(good_count), 34'(m_good));
      chk("t7_err_count", 34'(err_count), 34'(m_err));
      chk("t7_queue_empty", 34'(exp_q.size()), 34'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
